// File: rtl/testmasterslave3_feeder.sv
// Producer stage: FIFO-buffers a valid/notify input stream and re-emits it as a held value plus a one-cycle strobe on every PERIOD-cycle tick.
// Optional underrun counter port enabled by defining TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN.
module testmasterslave3_feeder #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter int               PERIOD    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1337)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_in_sync,
    output logic             b_in_notify,
    output logic [WIDTH-1:0] s_out,
    output logic             s_out_sync
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
    ,
    output logic [15:0]      underruns
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic [TW-1:0]    tick_cnt;
    logic             tick, push, pop;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign b_in_notify = (count != FULL_CNT);
    assign s_out_sync  = (state == EMIT);

    always_comb begin
        tick      = en && (tick_cnt == TICK_LAST);
        push      = b_in_sync && b_in_notify;
        pop       = tick && (count != '0);
        state_nxt = IDLE;
        case (state)
            IDLE: if (pop) state_nxt = EMIT;
            EMIT: state_nxt = pop ? EMIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            tick_cnt <= '0;
            s_out    <= RESET_VAL;
        end else begin
            state <= state_nxt;
            if (en) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                s_out  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= b_in;
    end

`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
    logic underrun;
    assign underrun = tick && (count == '0);

    always_ff @(posedge clk) begin
        if (rst)
            underruns <= '0;
        else if (underrun && underruns != 16'hFFFF)
            underruns <= underruns + 16'd1;
    end
`endif

endmodule

// File: tb/tb_testmasterslave3_feeder.sv
// Bench for testmasterslave3_feeder: constant vector table, queue-based reference model, and a PERIOD=1 streaming check.
module tb_testmasterslave3_feeder;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int PER   = 3;
    localparam logic [W-1:0] RV = 32'd1337;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] b_in = '0;
    logic         b_in_sync = 1'b0;
    logic         notify0, sync0, notify1, sync1;
    logic [W-1:0] sout0, sout1;
    logic [15:0]  under0, under1;

    always #5 clk = ~clk;

    testmasterslave3_feeder #(.WIDTH(W), .DEPTH(DEPTH), .PERIOD(PER)) dut (
        .clk(clk), .rst(rst), .en(en), .b_in(b_in), .b_in_sync(b_in_sync),
        .b_in_notify(notify0), .s_out(sout0), .s_out_sync(sync0)
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
        , .underruns(under0)
`endif
    );

    testmasterslave3_feeder #(.WIDTH(W), .DEPTH(DEPTH), .PERIOD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .b_in(b_in), .b_in_sync(b_in_sync),
        .b_in_notify(notify1), .s_out(sout1), .s_out_sync(sync1)
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
        , .underruns(under1)
`endif
    );

`ifndef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
    assign under0 = '0;
    assign under1 = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model for the PERIOD=3 instance
    logic [W-1:0] m_q[$];
    int           m_phase;
    logic [W-1:0] m_out;
    logic         m_sync;
    int           m_under;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [W-1:0] d, input logic s);
        bit tick, room;
        if (r) begin
            m_q.delete();
            m_phase = 0;
            m_out   = RV;
            m_sync  = 1'b0;
            m_under = 0;
        end else begin
            tick = e && (m_phase == PER - 1);
            if (e) m_phase = (m_phase + 1) % PER;
            room   = (m_q.size() != DEPTH);
            m_sync = 1'b0;
            if (tick) begin
                if (m_q.size() > 0) begin
                    m_out  = m_q.pop_front();
                    m_sync = 1'b1;
                end else if (m_under < 16'hFFFF) begin
                    m_under++;
                end
            end
            if (s && room) m_q.push_back(d);
        end
    endtask

    // Drive one cycle, advance the model, and compare the PERIOD=3 instance after the edge.
    task automatic step(input logic r, input logic e, input logic [W-1:0] d, input logic s);
        rst = r; en = e; b_in = d; b_in_sync = s;
        @(posedge clk);
        model_edge(r, e, d, s);
        #1;
        chk("model_s_out", sout0, m_out);
        chk("model_s_out_sync", {31'd0, sync0}, {31'd0, m_sync});
        chk("model_notify", {31'd0, notify0}, {31'd0, (m_q.size() != DEPTH)});
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
        chk("model_underruns", {16'd0, under0}, W'(m_under));
`endif
    endtask

    typedef struct {
        logic         r, e, s;
        logic [W-1:0] d;
        logic [W-1:0] so;
        logic         sy, nt;
    } vec_t;

    vec_t tbl[28];

    task automatic setv(input int i, input logic r, input logic e, input logic [W-1:0] d,
                        input logic s, input logic [W-1:0] so, input logic sy, input logic nt);
        tbl[i].r = r; tbl[i].e = e; tbl[i].d = d; tbl[i].s = s;
        tbl[i].so = so; tbl[i].sy = sy; tbl[i].nt = nt;
    endtask

    initial begin
        // reset, single push, underrun tick, fill to full, stalled 5th value, ordered drain
        setv(0, 1, 0, 0, 0, RV, 0, 1);    setv(1, 1, 0, 0, 0, RV, 0, 1);
        setv(2, 0, 1, 5, 1, RV, 0, 1);    setv(3, 0, 1, 0, 0, RV, 0, 1);
        setv(4, 0, 1, 0, 0, 5, 1, 1);     setv(5, 0, 1, 0, 0, 5, 0, 1);
        setv(6, 0, 1, 0, 0, 5, 0, 1);     setv(7, 0, 1, 0, 0, 5, 0, 1);
        setv(8, 0, 0, 10, 1, 5, 0, 1);    setv(9, 0, 0, 11, 1, 5, 0, 1);
        setv(10, 0, 0, 12, 1, 5, 0, 1);   setv(11, 0, 0, 13, 1, 5, 0, 0);
        setv(12, 0, 0, 14, 1, 5, 0, 0);   setv(13, 0, 1, 14, 1, 5, 0, 0);
        setv(14, 0, 1, 14, 1, 5, 0, 0);   setv(15, 0, 1, 14, 1, 10, 1, 1);
        setv(16, 0, 1, 14, 1, 10, 0, 0);  setv(17, 0, 1, 0, 0, 10, 0, 0);
        setv(18, 0, 1, 0, 0, 11, 1, 1);   setv(19, 0, 1, 0, 0, 11, 0, 1);
        setv(20, 0, 1, 0, 0, 11, 0, 1);   setv(21, 0, 1, 0, 0, 12, 1, 1);
        setv(22, 0, 1, 0, 0, 12, 0, 1);   setv(23, 0, 1, 0, 0, 12, 0, 1);
        setv(24, 0, 1, 0, 0, 13, 1, 1);   setv(25, 0, 1, 0, 0, 13, 0, 1);
        setv(26, 0, 1, 0, 0, 13, 0, 1);   setv(27, 0, 1, 0, 0, 14, 1, 1);

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].s);
            chk($sformatf("tbl%0d_s_out", i), sout0, tbl[i].so);
            chk($sformatf("tbl%0d_sync", i), {31'd0, sync0}, {31'd0, tbl[i].sy});
            chk($sformatf("tbl%0d_notify", i), {31'd0, notify0}, {31'd0, tbl[i].nt});
        end
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
        chk("tbl_underruns", {16'd0, under0}, 32'd1);
`endif

        // Empty FIFO for nine enabled cycles: three ticks, no strobes
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 0);
            chk("underrun_no_strobe", {31'd0, sync0}, 32'd0);
        end
        chk("underrun_s_out", sout0, RV);
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
        chk("underrun_count", {16'd0, under0}, 32'd3);
`endif

        // Mid-operation reset discards queued data
        for (int i = 0; i < 3; i++) step(0, 0, W'(100 + i), 1);
        step(1, 0, 0, 0);
        chk("midrst_s_out", sout0, RV);
        chk("midrst_notify", {31'd0, notify0}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("midrst_no_strobe", {31'd0, sync0}, 32'd0);
        end
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
        chk("midrst_underruns", {16'd0, under0}, 32'd1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 W'($urandom), 1'($urandom_range(0, 1)));

        // PERIOD=1 instance: continuous push of 1..8 gives back-to-back strobes
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, W'(k + 1), k < 8);
            chk($sformatf("p1_sync_k%0d", k), {31'd0, sync1}, {31'd0, (k >= 1 && k <= 8)});
            chk($sformatf("p1_s_out_k%0d", k), sout1, (k == 0) ? RV : W'((k > 8) ? 8 : k));
            chk($sformatf("p1_notify_k%0d", k), {31'd0, notify1}, 32'd1);
`ifdef TESTMASTERSLAVE3_FEEDER_UNDERRUN_EN
            chk($sformatf("p1_underruns_k%0d", k), {16'd0, under1}, (k == 9) ? 32'd2 : 32'd1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
